// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32IM decode stage: opcode/funct
// encodings, reservation-station and operand-select enums, ALU function
// codes, and the decoded micro-op struct handed to rename.
package decode_stage_pkg;

    // Architectural register index width
    localparam int ARF_IDX = 5;

    // RV32IM major opcodes
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // funct7 values that are meaningful for OP/OP-IMM
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        RS_INT  = 2'd0,
        RS_INTM = 2'd1,
        RS_BR   = 2'd2,
        RS_MEM  = 2'd3
    } rs_type_t;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_t;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_t;

    // ALU function codes: the low three bits follow funct3, bit 3 marks the
    // funct7[5] variants (SUB, SRA).
    typedef logic [3:0] fu_op_t;
    localparam fu_op_t ALU_ADD  = 4'b0000;
    localparam fu_op_t ALU_SLL  = 4'b0001;
    localparam fu_op_t ALU_SLT  = 4'b0010;
    localparam fu_op_t ALU_SLTU = 4'b0011;
    localparam fu_op_t ALU_XOR  = 4'b0100;
    localparam fu_op_t ALU_SRL  = 4'b0101;
    localparam fu_op_t ALU_OR   = 4'b0110;
    localparam fu_op_t ALU_AND  = 4'b0111;
    localparam fu_op_t ALU_SUB  = 4'b1000;
    localparam fu_op_t ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [31:0]          pc;
        rs_type_t             rs_type;
        fu_op_t               fu_opcode;
        op1_sel_t             op1_sel;
        op2_sel_t             op2_sel;
        logic [31:0]          imm;
        logic [ARF_IDX-1:0]   rd_arch;
        logic [ARF_IDX-1:0]   rs1_arch;
        logic [ARF_IDX-1:0]   rs2_arch;
        logic                 inst_invalid;
    } decode_uop_t;

    // ALU function for OP/OP-IMM. SUB only exists in register form; ADDI
    // ignores the immediate's bit that aliases funct7[5].
    function automatic fu_op_t alu_fu(input logic [2:0] funct3,
                                      input logic       funct7_b5,
                                      input logic       is_imm);
        fu_op_t fu;
        case (funct3)
            3'b000:  fu = (funct7_b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b010:  fu = ALU_SLT;
            3'b011:  fu = ALU_SLTU;
            3'b101:  fu = funct7_b5 ? ALU_SRA : ALU_SRL;
            default: fu = {1'b0, funct3};
        endcase
        return fu;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and rename-side handshake bundle of the decode stage.
// slave: the decode stage; master: the environment driving it.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int W = 2
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_lane_mask;
    logic [W*32-1:0]        in_inst;
    logic [W*32-1:0]        in_pc;

    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_lane_mask;
    decode_uop_t [W-1:0]    out_uop;

    modport master (
        output in_valid, in_lane_mask, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_lane_mask, out_uop
    );

    modport slave (
        input  in_valid, in_lane_mask, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_lane_mask, out_uop
    );

endinterface

// File: rtl/decode_stage_lane_decoder.sv
// rv32_lane_decoder: purely combinational RV32IM decode of one instruction
// into a decode_uop_t. Illegal-instruction policy is selected by the
// DECODE_STRICT_ILLEGAL_EN macro: defined -> full RV32IM legality check,
// undefined -> only an all-zero opcode field is flagged.
module rv32_lane_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0]  i_inst,
    input  logic [31:0]  i_pc,
    output decode_uop_t  o_uop
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};

`ifdef DECODE_STRICT_ILLEGAL_EN
    // Full RV32IM legality: opcode, funct3 and funct7 combinations
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_illegal = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC, OP_JAL: w_illegal = 1'b0;
            OP_JALR:  w_illegal = (w_funct3 != 3'b000);
            OP_BR:    w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            OP_LOAD:  w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                  (w_funct3 == 3'b111);
            OP_STORE: w_illegal = (w_funct3 > 3'b010);
            OP_IMM: begin
                case (w_funct3)
                    3'b001:  w_illegal = (w_funct7 != F7_BASE);
                    3'b101:  w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                    default: w_illegal = 1'b0;
                endcase
            end
            OP_REG: begin
                if ((w_funct7 == F7_BASE) || (w_funct7 == F7_MULDIV)) begin
                    w_illegal = 1'b0;
                end else if (w_funct7 == F7_ALT) begin
                    w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end
`else
    assign w_illegal = (w_opcode == 7'b0);
`endif

    // Field extraction, reservation-station routing and operand selection
    always_comb begin
        o_uop         = '0;
        o_uop.pc      = i_pc;
        o_uop.rs_type = RS_INT;
        o_uop.op1_sel = OP1_ZERO;
        o_uop.op2_sel = OP2_RS2;
        case (w_opcode)
            OP_LUI: begin
                o_uop.rd_arch = i_inst[11:7];
                o_uop.op2_sel = OP2_IMM;
                o_uop.imm     = w_imm_u;
            end
            OP_AUIPC: begin
                o_uop.rd_arch = i_inst[11:7];
                o_uop.op1_sel = OP1_PC;
                o_uop.op2_sel = OP2_IMM;
                o_uop.imm     = w_imm_u;
            end
            OP_IMM: begin
                o_uop.rd_arch   = i_inst[11:7];
                o_uop.rs1_arch  = i_inst[19:15];
                o_uop.op1_sel   = OP1_RS1;
                o_uop.op2_sel   = OP2_IMM;
                o_uop.imm       = w_imm_i;
                o_uop.fu_opcode = alu_fu(w_funct3, w_funct7[5], 1'b1);
            end
            OP_REG: begin
                o_uop.rd_arch  = i_inst[11:7];
                o_uop.rs1_arch = i_inst[19:15];
                o_uop.rs2_arch = i_inst[24:20];
                o_uop.op1_sel  = OP1_RS1;
                o_uop.op2_sel  = OP2_RS2;
                if (w_funct7 == F7_MULDIV) begin
                    o_uop.rs_type   = RS_INTM;
                    o_uop.fu_opcode = {1'b0, w_funct3};
                end else begin
                    o_uop.fu_opcode = alu_fu(w_funct3, w_funct7[5], 1'b0);
                end
            end
            OP_JAL: begin
                o_uop.rd_arch   = i_inst[11:7];
                o_uop.rs_type   = RS_BR;
                o_uop.op1_sel   = OP1_PC;
                o_uop.op2_sel   = OP2_IMM;
                o_uop.imm       = w_imm_j;
                o_uop.fu_opcode = ALU_ADD;
            end
            OP_JALR: begin
                o_uop.rd_arch   = i_inst[11:7];
                o_uop.rs1_arch  = i_inst[19:15];
                o_uop.rs_type   = RS_BR;
                o_uop.op1_sel   = OP1_RS1;
                o_uop.op2_sel   = OP2_IMM;
                o_uop.imm       = w_imm_i;
                o_uop.fu_opcode = ALU_ADD;
            end
            OP_BR: begin
                o_uop.rs1_arch  = i_inst[19:15];
                o_uop.rs2_arch  = i_inst[24:20];
                o_uop.rs_type   = RS_BR;
                o_uop.op1_sel   = OP1_RS1;
                o_uop.op2_sel   = OP2_RS2;
                o_uop.imm       = w_imm_b;
                o_uop.fu_opcode = {1'b0, w_funct3};
            end
            OP_LOAD: begin
                o_uop.rd_arch   = i_inst[11:7];
                o_uop.rs1_arch  = i_inst[19:15];
                o_uop.rs_type   = RS_MEM;
                o_uop.op1_sel   = OP1_RS1;
                o_uop.op2_sel   = OP2_IMM;
                o_uop.imm       = w_imm_i;
                o_uop.fu_opcode = {1'b0, w_funct3};
            end
            OP_STORE: begin
                o_uop.rs1_arch  = i_inst[19:15];
                o_uop.rs2_arch  = i_inst[24:20];
                o_uop.rs_type   = RS_MEM;
                o_uop.op1_sel   = OP1_RS1;
                o_uop.op2_sel   = OP2_IMM;
                o_uop.imm       = w_imm_s;
                o_uop.fu_opcode = {1'b0, w_funct3};
            end
            default: ;
        endcase
        // Invalid lanes travel on, but must not claim registers or a special RS
        if (w_illegal) begin
            o_uop.rs_type  = RS_INT;
            o_uop.rd_arch  = '0;
            o_uop.rs1_arch = '0;
            o_uop.rs2_arch = '0;
        end
        o_uop.inst_invalid = w_illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: superscalar RV32IM decode between fetch queue and rename.
// DECODE_WIDTH lane decoders feed a QUEUE_DEPTH-entry bundle queue so that
// fetch only ever sees a ready derived from registered occupancy.
// Optional macro DECODE_STRICT_ILLEGAL_EN enables full RV32IM illegal checks.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int QUEUE_DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    decode_uop_t [DECODE_WIDTH-1:0] w_dec_uop;
    decode_uop_t [DECODE_WIDTH-1:0] w_lane_uop;

    decode_uop_t [DECODE_WIDTH-1:0] r_mem_uop  [QUEUE_DEPTH];
    logic        [DECODE_WIDTH-1:0] r_mem_mask [QUEUE_DEPTH];
    logic        [PTR_W-1:0]        r_head;
    logic        [PTR_W-1:0]        r_tail;
    logic        [CNT_W-1:0]        r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        rv32_lane_decoder u_dec (
            .i_inst (bus.in_inst[32*g +: 32]),
            .i_pc   (bus.in_pc[32*g +: 32]),
            .o_uop  (w_dec_uop[g])
        );
    end

    // Lanes outside the fetch mask are stored as all-zero uops
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            w_lane_uop[i] = bus.in_lane_mask[i] ? w_dec_uop[i] : '0;
        end
    end

    assign w_empty      = (r_count == '0);
    assign bus.in_ready  = (r_count < DEPTH_C);
    assign bus.out_valid = !w_empty;

    // A flush cancels whatever handshake would otherwise complete this cycle
    assign w_push = bus.in_valid && bus.in_ready && !flush;
    assign w_pop  = bus.out_valid && bus.out_ready && !flush;

    assign bus.out_uop       = w_empty ? '0 : r_mem_uop[r_head];
    assign bus.out_lane_mask = w_empty ? '0 : r_mem_mask[r_head];

    // Queue pointers and occupancy; flush empties, push/pop move the ends
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with <= so every register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bundle storage written at the tail on each accepted push
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy gates every read, so stale contents are never visible.
        if (w_push) begin
            r_mem_uop[r_tail]  <= w_lane_uop;
            r_mem_mask[r_tail] <= bus.in_lane_mask;
        end
    end

endmodule
